// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, issues one 32-bit imem read at a time
// and presents the IF/ID register, with a 1-entry skid buffer to absorb stalls.
module ifetch_unit #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic [6:0]      if_id_opcode
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_DRAIN} state_t;

    state_t          r_state, w_state_d;
    logic [XLEN-1:0] r_pc, r_req_pc, r_skid_pc, r_if_pc;
    logic [31:0]     r_skid_instr, r_if_instr;
    logic            r_skid_valid, r_if_valid;

    logic            w_req, w_fire, w_pending, w_resp, w_load_if;
    logic [31:0]     w_instr;

    assign w_req     = !rst && (r_state == S_FETCH) && !r_skid_valid;
    assign w_fire    = w_req && imem_gnt;
    // An earlier request stays unanswered past this cycle.
    assign w_pending = (r_state != S_FETCH) && !imem_rvalid;
    assign w_resp    = imem_rvalid && (r_state == S_WAIT) && !redirect_valid;
    assign w_load_if = !stall || !r_if_valid;

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_FETCH: if (w_fire)      w_state_d = S_WAIT;
            S_WAIT:  if (imem_rvalid) w_state_d = S_FETCH;
            S_DRAIN: if (imem_rvalid) w_state_d = S_FETCH;
            default:                  w_state_d = S_FETCH;
        endcase
        if (redirect_valid)
            w_state_d = (w_pending || w_fire) ? S_DRAIN : S_FETCH;
    end

    // Reset drains a request left in flight so its late response is dropped.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= w_pending ? S_DRAIN : S_FETCH;
        else
            r_state <= w_state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_req_pc     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
            r_if_valid   <= 1'b0;
            r_if_pc      <= '0;
            r_if_instr   <= '0;
        end else if (redirect_valid) begin
            r_pc         <= {redirect_pc[XLEN-1:2], 2'b00};
            r_skid_valid <= 1'b0;
            r_if_valid   <= 1'b0;
        end else begin
            if (w_fire) begin
                r_pc     <= r_pc + XLEN'(4);
                r_req_pc <= r_pc;
            end
            if (w_load_if) begin
                if (r_skid_valid) begin
                    r_if_valid <= 1'b0 | 1'b1;
                    r_if_pc    <= r_skid_pc;
                    r_if_instr <= r_skid_instr;
                    if (w_resp) begin
                        r_skid_pc    <= r_req_pc;
                        r_skid_instr <= imem_rdata;
                    end else begin
                        r_skid_valid <= 1'b0;
                    end
                end else if (w_resp) begin
                    r_if_valid <= 1'b1;
                    r_if_pc    <= r_req_pc;
                    r_if_instr <= imem_rdata;
                end else begin
                    r_if_valid <= 1'b0;
                end
            end else if (w_resp) begin
                r_skid_valid <= 1'b1;
                r_skid_pc    <= r_req_pc;
                r_skid_instr <= imem_rdata;
            end
        end
    end

    assign w_instr      = r_if_valid ? r_if_instr : '0;
    assign imem_req     = w_req;
    assign imem_addr    = r_pc;
    assign if_id_valid  = r_if_valid;
    assign if_id_pc     = r_if_pc;
    assign if_id_instr  = w_instr;
    assign if_id_opcode = w_instr[6:0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus a randomized run checked
// against a program-order model of expected fetch and consume addresses.
module tb_ifetch_unit;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, stall = 1'b0, redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  if_id_opcode;

    ifetch_unit #(.XLEN(64), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode)
    );

    int          n_cmp = 0, n_fail = 0;
    int unsigned cyc = 0;

    // memory model state and knobs
    int unsigned gnt_pct = 100, lat_min = 1, lat_max = 1;
    logic        pend = 1'b0;
    logic [63:0] pend_addr = '0;
    int unsigned pend_due = 0;

    // per-cycle snapshot
    logic        s_rst, s_stall, s_redir, s_req, s_gnt, s_rvalid, s_overlap, s_valid;
    logic [63:0] s_rpc, s_addr, s_pc;
    logic [31:0] s_instr;
    logic [6:0]  s_op;

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic step();
        #1;
        imem_rvalid = pend && (cyc >= pend_due);
        imem_rdata  = imem_rvalid ? word_of(pend_addr) : $urandom();
        s_overlap   = imem_req && pend;
        imem_gnt    = imem_req && !pend && ($urandom_range(99) < gnt_pct);
        #1;
        s_rst = rst; s_stall = stall; s_redir = redirect_valid; s_rpc = redirect_pc;
        s_req = imem_req; s_addr = imem_addr; s_gnt = imem_gnt; s_rvalid = imem_rvalid;
        s_valid = if_id_valid; s_pc = if_id_pc; s_instr = if_id_instr; s_op = if_id_opcode;
        if (imem_rvalid) pend = 1'b0;
        if (imem_req && imem_gnt) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_due  = cyc + $urandom_range(lat_max, lat_min);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        repeat (n) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (s_req !== 1'b0) begin
                n_fail++; $display("FAIL reset_req: got %b want 0", s_req);
            end
            if (i >= 1) begin
                n_cmp++;
                if (s_valid !== 1'b0 || s_pc !== 64'h0 || s_instr !== 32'h0 || s_op !== 7'h0) begin
                    n_fail++;
                    $display("FAIL reset_ifid: got v=%b pc=%h ins=%h op=%h want all 0",
                             s_valid, s_pc, s_instr, s_op);
                end
            end
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (s_req !== 1'b1 || s_addr !== RST_PC) begin
            n_fail++; $display("FAIL first_req: got req=%b addr=%h want 1 %h", s_req, s_addr, RST_PC);
        end
    endtask

    task automatic test_stream();
        logic [63:0] epc;
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset(5);
        for (int c = 0; c < 10; c++) begin
            step();
            n_cmp++;
            if (s_req !== ((c % 2) == 0)) begin
                n_fail++; $display("FAIL stream_req c%0d: got %b want %b", c, s_req, (c % 2) == 0);
            end
            if (c >= 2) begin
                epc = RST_PC + 64'(4 * (c / 2 - 1));
                n_cmp++;
                if ((c % 2) == 0) begin
                    if (s_valid !== 1'b1 || s_pc !== epc || s_instr !== word_of(epc)) begin
                        n_fail++;
                        $display("FAIL stream_ifid c%0d: got v=%b pc=%h ins=%h want 1 %h %h",
                                 c, s_valid, s_pc, s_instr, epc, word_of(epc));
                    end
                end else if (s_valid !== 1'b0 || s_instr !== 32'h0) begin
                    n_fail++; $display("FAIL stream_gap c%0d: got v=%b ins=%h want 0 0", c, s_valid, s_instr);
                end
            end
        end
    endtask

    task automatic test_stall();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset(5);
        for (int c = 0; c < 10; c++) begin
            stall = (c >= 2 && c <= 7);
            step();
            if (c >= 3 && c <= 8) begin
                n_cmp++;
                if (s_valid !== 1'b1 || s_pc !== RST_PC || s_instr !== word_of(RST_PC)) begin
                    n_fail++; $display("FAIL stall_hold c%0d: got v=%b pc=%h want 1 %h", c, s_valid, s_pc, RST_PC);
                end
            end
            if (c >= 4 && c <= 8) begin
                n_cmp++;
                if (s_req !== 1'b0) begin
                    n_fail++; $display("FAIL stall_req c%0d: got %b want 0", c, s_req);
                end
            end
            if (c == 9) begin
                n_cmp++;
                if (s_valid !== 1'b1 || s_pc !== RST_PC + 4 || s_instr !== word_of(RST_PC + 4)
                    || s_req !== 1'b1 || s_addr !== RST_PC + 8) begin
                    n_fail++;
                    $display("FAIL stall_release: got v=%b pc=%h req=%b addr=%h want 1 %h 1 %h",
                             s_valid, s_pc, s_req, s_addr, RST_PC + 4, RST_PC + 8);
                end
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_redirect_wait();
        gnt_pct = 100; lat_min = 2; lat_max = 2;
        do_reset(5);
        for (int c = 0; c < 10; c++) begin
            redirect_valid = (c == 4);
            redirect_pc    = 64'h2002;
            step();
            if (c == 5) begin
                n_cmp++;
                if (s_valid !== 1'b0 || s_req !== 1'b0 || s_rvalid !== 1'b1) begin
                    n_fail++; $display("FAIL rdw_drain: got v=%b req=%b rv=%b want 0 0 1", s_valid, s_req, s_rvalid);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 64'h2000) begin
                    n_fail++; $display("FAIL rdw_target: got v=%b req=%b addr=%h want 0 1 2000", s_valid, s_req, s_addr);
                end
            end
            if (c == 9) begin
                n_cmp++;
                if (s_valid !== 1'b1 || s_pc !== 64'h2000 || s_instr !== word_of(64'h2000)) begin
                    n_fail++; $display("FAIL rdw_ifid: got v=%b pc=%h want 1 2000", s_valid, s_pc);
                end
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_redirect_grant();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset(5);
        for (int c = 0; c < 7; c++) begin
            redirect_valid = (c == 2);
            redirect_pc    = 64'h3000;
            step();
            if (c == 2) begin
                n_cmp++;
                if (s_req !== 1'b1 || s_gnt !== 1'b1 || s_addr !== RST_PC + 4) begin
                    n_fail++; $display("FAIL rdg_fire: got req=%b gnt=%b addr=%h want 1 1 %h", s_req, s_gnt, s_addr, RST_PC + 4);
                end
            end
            if (c == 3 || c == 5) begin
                n_cmp++;
                if (s_valid !== 1'b0 || (c == 3 && s_req !== 1'b0)) begin
                    n_fail++; $display("FAIL rdg_drain c%0d: got v=%b req=%b want 0", c, s_valid, s_req);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 64'h3000) begin
                    n_fail++; $display("FAIL rdg_target: got v=%b req=%b addr=%h want 0 1 3000", s_valid, s_req, s_addr);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (s_valid !== 1'b1 || s_pc !== 64'h3000) begin
                    n_fail++; $display("FAIL rdg_ifid: got v=%b pc=%h want 1 3000", s_valid, s_pc);
                end
            end
        end
        redirect_valid = 1'b0;
    endtask

    task automatic test_redirect_rvalid_stall();
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        do_reset(5);
        for (int c = 0; c < 7; c++) begin
            stall          = (c >= 2);
            redirect_valid = (c == 3);
            redirect_pc    = 64'h4004;
            step();
            if (c == 3) begin
                n_cmp++;
                if (s_rvalid !== 1'b1 || s_valid !== 1'b1) begin
                    n_fail++; $display("FAIL rrs_setup: got rv=%b v=%b want 1 1", s_rvalid, s_valid);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (s_valid !== 1'b0 || s_instr !== 32'h0 || s_req !== 1'b1 || s_addr !== 64'h4004) begin
                    n_fail++; $display("FAIL rrs_target: got v=%b ins=%h req=%b addr=%h want 0 0 1 4004",
                                       s_valid, s_instr, s_req, s_addr);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (s_valid !== 1'b1 || s_pc !== 64'h4004 || s_instr !== word_of(64'h4004)) begin
                    n_fail++; $display("FAIL rrs_ifid: got v=%b pc=%h want 1 4004", s_valid, s_pc);
                end
            end
        end
        stall = 1'b0; redirect_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        gnt_pct = 100; lat_min = 3; lat_max = 3;
        do_reset(5);
        for (int c = 0; c < 9; c++) begin
            rst = (c == 1 || c == 2);
            step();
            if (c == 3) begin
                n_cmp++;
                if (s_req !== 1'b0 || s_rvalid !== 1'b1) begin
                    n_fail++; $display("FAIL rstmid_drain: got req=%b rv=%b want 0 1", s_req, s_rvalid);
                end
            end
            if (c == 4) begin
                n_cmp++;
                if (s_req !== 1'b1 || s_addr !== RST_PC || s_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rstmid_req: got req=%b addr=%h v=%b want 1 %h 0", s_req, s_addr, s_valid, RST_PC);
                end
            end
            if (c == 8) begin
                n_cmp++;
                if (s_valid !== 1'b1 || s_pc !== RST_PC) begin
                    n_fail++; $display("FAIL rstmid_ifid: got v=%b pc=%h want 1 %h", s_valid, s_pc, RST_PC);
                end
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [63:0] exp_fetch, exp_pc, tgt, p_pc, p_addr;
        logic [31:0] p_instr;
        logic        p_hold, p_kill, p_waitaddr;
        int          consumed;
        gnt_pct = 60; lat_min = 1; lat_max = 4;
        do_reset(5);
        exp_fetch = RST_PC; exp_pc = RST_PC;
        p_hold = 1'b0; p_kill = 1'b0; p_waitaddr = 1'b0; p_pc = '0; p_addr = '0; p_instr = '0;
        consumed = 0;
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(199) == 0);
            stall          = ($urandom_range(99) < 30);
            redirect_valid = ($urandom_range(99) < 5);
            redirect_pc    = ($urandom_range(3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15)))
                                                      : {$urandom(), $urandom()};
            step();
            tgt = {s_rpc[63:2], 2'b00};

            n_cmp++;
            if (s_op !== s_instr[6:0] || (!s_valid && s_instr !== 32'h0)) begin
                n_fail++; $display("FAIL rnd_zero cyc%0d: got v=%b ins=%h op=%h", cyc, s_valid, s_instr, s_op);
            end
            n_cmp++;
            if (s_overlap !== 1'b0 || (s_rst && s_req !== 1'b0)) begin
                n_fail++; $display("FAIL rnd_proto cyc%0d: got overlap=%b rst=%b req=%b want no req", cyc, s_overlap, s_rst, s_req);
            end
            if (s_req && s_gnt) begin
                n_cmp++;
                if (s_addr !== exp_fetch) begin
                    n_fail++; $display("FAIL rnd_addr cyc%0d: got %h want %h", cyc, s_addr, exp_fetch);
                end
                exp_fetch = exp_fetch + 64'd4;
            end
            if (p_waitaddr && !s_rst) begin
                n_cmp++;
                if (s_req !== 1'b1 || s_addr !== p_addr) begin
                    n_fail++; $display("FAIL rnd_hold_addr cyc%0d: got req=%b addr=%h want 1 %h", cyc, s_req, s_addr, p_addr);
                end
            end
            if (p_hold) begin
                n_cmp++;
                if (s_valid !== 1'b1 || s_pc !== p_pc || s_instr !== p_instr) begin
                    n_fail++; $display("FAIL rnd_stall_hold cyc%0d: got v=%b pc=%h want 1 %h", cyc, s_valid, s_pc, p_pc);
                end
            end
            if (p_kill) begin
                n_cmp++;
                if (s_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rnd_kill cyc%0d: got v=%b want 0", cyc, s_valid);
                end
            end
            if (s_valid === 1'b1 && !s_stall && !s_redir && !s_rst) begin
                n_cmp++;
                if (s_pc !== exp_pc || s_instr !== word_of(exp_pc)) begin
                    n_fail++; $display("FAIL rnd_consume cyc%0d: got pc=%h ins=%h want %h %h",
                                       cyc, s_pc, s_instr, exp_pc, word_of(exp_pc));
                end
                exp_pc = exp_pc + 64'd4;
                consumed++;
            end
            if (s_rst) begin
                exp_fetch = RST_PC; exp_pc = RST_PC;
            end else if (s_redir) begin
                exp_fetch = tgt; exp_pc = tgt;
            end
            p_hold     = s_valid && s_stall && !s_redir && !s_rst;
            p_kill     = s_redir || s_rst;
            p_waitaddr = s_req && !s_gnt && !s_redir && !s_rst;
            p_pc = s_pc; p_instr = s_instr; p_addr = s_addr;
        end
        rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        n_cmp++;
        if (consumed < 100) begin
            n_fail++; $display("FAIL rnd_progress: got %0d consumed want >= 100", consumed);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_grant();
        test_redirect_rvalid_stall();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
